// File: rtl/sim_end_monitor.sv
// End-of-test monitor: counts cycles/retired instructions, detects tohost retirement, enforces a watchdog
// and (with SIM_END_SIG_CHECK_EN defined) compares the signature region against an expected list.
module sim_end_monitor #(
  parameter int              XLEN             = 32,
  parameter int              CNT_W            = 32,
  parameter logic [XLEN-1:0] TOHOST_PC        = 32'h00000086,
  parameter int              TOHOST_HITS      = 8,
  parameter int              TIMEOUT_CYCLES   = 50000,
  parameter logic [XLEN-1:0] SIG_BASE_DEFAULT = 32'h00002000,
  parameter int              SIG_WORDS        = 1024
) (
  input  logic             clk,
  input  logic             cpurst,
  input  logic             inst_valid,
  input  logic [XLEN-1:0]  inst_pc,
  input  logic [XLEN-1:0]  gp_value,
  input  logic [XLEN-1:0]  sig_base,
  output logic             mem_rd_en,
  output logic [XLEN-1:0]  mem_rd_addr,
  input  logic [XLEN-1:0]  mem_rd_data,
  output logic [CNT_W-1:0] ref_rd_idx,
  input  logic [XLEN-1:0]  ref_rd_data,
  input  logic             ref_rd_valid,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count,
  output logic [CNT_W-1:0] words_checked,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_mismatch_idx
);

  localparam logic [CNT_W-1:0] HITS_C    = CNT_W'(TOHOST_HITS);
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_SCAN_REQ = 2'd1,
    S_SCAN_CMP = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_hits;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;

  logic             w_hit;
  logic [CNT_W-1:0] w_hits_inc;
  logic             w_end;
  logic             w_to;

  assign w_hit      = inst_valid && (inst_pc == TOHOST_PC);
  assign w_hits_inc = r_hits + ONE_C;
  // End beats timeout when both land on the same RUN cycle.
  assign w_end      = (r_state == S_RUN) && w_hit && (w_hits_inc == HITS_C);
  assign w_to       = (r_state == S_RUN) && !w_end && (r_cycle == TO_LAST_C);

`ifdef SIM_END_SIG_CHECK_EN
  localparam logic [CNT_W-1:0] SIGW_C = CNT_W'(SIG_WORDS);

  logic [CNT_W-1:0] r_words;
  logic [CNT_W-1:0] r_mism;
  logic [CNT_W-1:0] r_first;
  logic             r_mem_rd_en;
  logic [XLEN-1:0]  r_base;

  logic             w_diff;
  logic [CNT_W-1:0] w_words_inc;
  logic [CNT_W-1:0] w_mism_inc;
  logic             w_pass_scan;
  logic             w_unused_gp;

  assign w_diff      = (mem_rd_data != ref_rd_data);
  assign w_words_inc = r_words + ONE_C;
  assign w_mism_inc  = r_mism + (w_diff ? ONE_C : '0);
  assign w_pass_scan = ref_rd_valid ? ((w_mism_inc == '0) && (w_words_inc != '0))
                                    : ((r_mism == '0) && (r_words != '0));
  assign w_unused_gp = ^gp_value;
`else
  logic w_gp_one;
  logic w_unused_sig;

  assign w_gp_one     = (gp_value == XLEN'(1));
  assign w_unused_sig = ^{mem_rd_data, ref_rd_data, ref_rd_valid, sig_base};
`endif

  always_ff @(posedge clk) begin
    if (cpurst) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_end) begin
`ifdef SIM_END_SIG_CHECK_EN
          w_state_nxt = S_SCAN_REQ;
`else
          w_state_nxt = S_DONE;
`endif
        end else if (w_to) begin
          w_state_nxt = S_DONE;
        end
      end
`ifdef SIM_END_SIG_CHECK_EN
      S_SCAN_REQ: w_state_nxt = S_SCAN_CMP;
      S_SCAN_CMP: begin
        if (!ref_rd_valid || (w_words_inc == SIGW_C)) w_state_nxt = S_DONE;
        else                                          w_state_nxt = S_SCAN_REQ;
      end
`endif
      default: w_state_nxt = r_state;
    endcase
  end

  // Counters and result flags; everything holds once DONE is reached.
  always_ff @(posedge clk) begin
    if (cpurst) begin
      r_cycle     <= '0;
      r_instret   <= '0;
      r_hits      <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef SIM_END_SIG_CHECK_EN
      r_words     <= '0;
      r_mism      <= '0;
      r_first     <= '1;
      r_mem_rd_en <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (!w_to)      r_cycle   <= r_cycle + ONE_C;
          if (inst_valid) r_instret <= r_instret + ONE_C;
          if (w_hit)      r_hits    <= w_hits_inc;
          if (w_end) begin
`ifdef SIM_END_SIG_CHECK_EN
            r_mem_rd_en <= 1'b1;
`else
            r_done      <= 1'b1;
            r_pass      <= w_gp_one;
`endif
          end else if (w_to) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end
        end
`ifdef SIM_END_SIG_CHECK_EN
        S_SCAN_REQ: r_mem_rd_en <= 1'b0;
        S_SCAN_CMP: begin
          if (ref_rd_valid) begin
            r_words <= w_words_inc;
            if (w_diff) begin
              r_mism <= w_mism_inc;
              if (r_first == '1) r_first <= r_words;
            end
          end
          if (w_state_nxt == S_DONE) begin
            r_done <= 1'b1;
            r_pass <= w_pass_scan;
          end else begin
            r_mem_rd_en <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SIM_END_SIG_CHECK_EN
  // Signature base is captured once, on the cycle the run ends.
  always_ff @(posedge clk) begin
    if (w_end) r_base <= (sig_base != '0) ? sig_base : SIG_BASE_DEFAULT;
  end

  assign mem_rd_en          = r_mem_rd_en;
  assign mem_rd_addr        = r_base + (XLEN'(r_words) << 2);
  assign ref_rd_idx         = r_words;
  assign words_checked      = r_words;
  assign mismatch_count     = r_mism;
  assign first_mismatch_idx = r_first;
`else
  assign mem_rd_en          = 1'b0;
  assign mem_rd_addr        = '0;
  assign ref_rd_idx         = '0;
  assign words_checked      = '0;
  assign mismatch_count     = '0;
  assign first_mismatch_idx = '1;
`endif

  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign cycle_count   = r_cycle;
  assign instret_count = r_instret;

endmodule

// File: tb/tb_sim_end_monitor.sv
// Directed bench for sim_end_monitor: table-driven RUN sequence plus hand-written end/timeout/scan cases.
module tb_sim_end_monitor;

  localparam logic [31:0] H = 32'h00000086;
  localparam logic [31:0] O = 32'h00000100;
`ifdef SIM_END_SIG_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        cpurst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_pc = '0;
  logic [31:0] gp_value = 32'd1;
  logic [31:0] sig_base = '0;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] ref_rd_idx;
  logic [31:0] ref_rd_data;
  logic        ref_rd_valid;
  logic        done, pass, timeout;
  logic [31:0] cycle_count, instret_count, words_checked, mismatch_count, first_mismatch_idx;

  logic [31:0] mem_img [0:15];
  logic [31:0] ref_img [0:15];
  logic [31:0] addr_log [0:15];
  logic [31:0] tb_base = 32'h2000;
  int          ref_len = 0;
  logic        log_clr = 1'b0;
  logic [31:0] n_log;

  int n_cmp = 0;
  int n_bad = 0;

  sim_end_monitor #(
    .TIMEOUT_CYCLES(100),
    .SIG_WORDS(6)
  ) dut (
    .clk(clk), .cpurst(cpurst), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .gp_value(gp_value), .sig_base(sig_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .ref_rd_idx(ref_rd_idx), .ref_rd_data(ref_rd_data), .ref_rd_valid(ref_rd_valid),
    .done(done), .pass(pass), .timeout(timeout),
    .cycle_count(cycle_count), .instret_count(instret_count),
    .words_checked(words_checked), .mismatch_count(mismatch_count),
    .first_mismatch_idx(first_mismatch_idx)
  );

  always #5 clk = ~clk;

  // Memory and reference-list responders: data returned the cycle after the request.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_img[4'((mem_rd_addr - tb_base) >> 2)];
    ref_rd_data  <= ref_img[ref_rd_idx[3:0]];
    ref_rd_valid <= (ref_rd_idx < 32'(ref_len));
    if (log_clr) n_log <= '0;
    else if (mem_rd_en) begin
      addr_log[n_log[3:0]] <= mem_rd_addr;
      n_log <= n_log + 32'd1;
    end
  end

  typedef struct {
    bit          iv;
    logic [31:0] pc;
    logic [31:0] e_cyc;
    logic [31:0] e_inst;
    bit          e_done;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inst_valid = 1'b0;
    cpurst = 1'b1;
    log_clr = 1'b1;
    step();
    cpurst = 1'b0;
    log_clr = 1'b0;
  endtask

  task automatic run_hits(input int n);
    for (int i = 0; i < n; i++) begin
      inst_valid = 1'b1;
      inst_pc = H;
      step();
    end
    inst_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string nm);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: done not seen within %0d cycles", nm, bound);
    end
  endtask

  task automatic setup_sig(input logic [31:0] sb, input logic [31:0] tbb, input int len);
    sig_base = sb;
    tb_base = tbb;
    ref_len = len;
    for (int i = 0; i < 16; i++) begin
      mem_img[i] = 32'hA5000000 + 32'(i);
      ref_img[i] = 32'hA5000000 + 32'(i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, H, 32'd1,  32'd1,  1'b0};
    tbl[1]  = '{1'b1, O, 32'd2,  32'd2,  1'b0};
    tbl[2]  = '{1'b1, H, 32'd3,  32'd3,  1'b0};
    tbl[3]  = '{1'b1, H, 32'd4,  32'd4,  1'b0};
    tbl[4]  = '{1'b0, H, 32'd5,  32'd4,  1'b0};
    tbl[5]  = '{1'b1, O, 32'd6,  32'd5,  1'b0};
    tbl[6]  = '{1'b1, H, 32'd7,  32'd6,  1'b0};
    tbl[7]  = '{1'b1, H, 32'd8,  32'd7,  1'b0};
    tbl[8]  = '{1'b0, O, 32'd9,  32'd7,  1'b0};
    tbl[9]  = '{1'b1, H, 32'd10, 32'd8,  1'b0};
    tbl[10] = '{1'b1, O, 32'd11, 32'd9,  1'b0};
    tbl[11] = '{1'b1, H, 32'd12, 32'd10, 1'b0};
    tbl[12] = '{1'b1, H, 32'd13, 32'd11, !FEAT};

    // Case 1: eight tohost hits among other instructions, gp=1.
    setup_sig(32'h0, 32'h2000, 1);
    gp_value = 32'd1;
    do_reset();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_instret", instret_count, 32'd0);
    chk("rst_words", words_checked, 32'd0);
    chk("rst_mism", mismatch_count, 32'd0);
    chk("rst_first", first_mismatch_idx, 32'hFFFFFFFF);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    for (int i = 0; i < 13; i++) begin
      inst_valid = tbl[i].iv;
      inst_pc = tbl[i].pc;
      step();
      chk($sformatf("t%0d_cycle", i), cycle_count, tbl[i].e_cyc);
      chk($sformatf("t%0d_instret", i), instret_count, tbl[i].e_inst);
      chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].e_done));
    end
    inst_valid = 1'b1;
    inst_pc = H;
    step();
    chk("c1_cycle_frozen", cycle_count, 32'd13);
    chk("c1_instret_frozen", instret_count, 32'd11);
    wait_done(40, "c1_done");
    step();
    chk("c1_pass", 32'(pass), 32'd1);
    chk("c1_timeout", 32'(timeout), 32'd0);
    chk("c1_cycle_final", cycle_count, 32'd13);
    chk("c1_instret_final", instret_count, 32'd11);
    chk("c1_words", words_checked, FEAT ? 32'd1 : 32'd0);
    inst_valid = 1'b0;

    // Case 2: no hits, watchdog fires after 100 RUN cycles.
    do_reset();
    inst_valid = 1'b1;
    inst_pc = O;
    for (int i = 0; i < 99; i++) step();
    chk("c2_cycle99", cycle_count, 32'd99);
    chk("c2_not_done", 32'(done), 32'd0);
    step();
    chk("c2_done", 32'(done), 32'd1);
    chk("c2_timeout", 32'(timeout), 32'd1);
    chk("c2_pass", 32'(pass), 32'd0);
    chk("c2_cycle", cycle_count, 32'd99);
    inst_pc = H;
    for (int i = 0; i < 10; i++) step();
    chk("c2_hold_cycle", cycle_count, 32'd99);
    chk("c2_hold_done", 32'(done), 32'd1);
    chk("c2_hold_rd_en", 32'(mem_rd_en), 32'd0);
    inst_valid = 1'b0;

    // Case 3: eighth hit lands on the timeout cycle; end wins.
    setup_sig(32'h0, 32'h2000, 2);
    do_reset();
    run_hits(7);
    for (int i = 0; i < 92; i++) step();
    chk("c3_cycle99", cycle_count, 32'd99);
    run_hits(1);
    chk("c3_cycle", cycle_count, 32'd100);
    chk("c3_instret", instret_count, 32'd8);
    chk("c3_timeout", 32'(timeout), 32'd0);
    chk("c3_rd_en", 32'(mem_rd_en), 32'(FEAT));
    chk("c3_done", 32'(done), 32'(!FEAT));
    wait_done(40, "c3_done_wait");
    chk("c3_pass", 32'(pass), 32'd1);
    chk("c3_timeout_end", 32'(timeout), 32'd0);

`ifdef SIM_END_SIG_CHECK_EN
    // Case 4: default base, four matching words, fifth marked invalid.
    setup_sig(32'h0, 32'h2000, 4);
    do_reset();
    run_hits(8);
    wait_done(40, "c4_done");
    chk("c4_nreads", n_log, 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("c4_addr%0d", i), addr_log[i], 32'h2000 + 32'(4 * i));
    chk("c4_words", words_checked, 32'd4);
    chk("c4_mism", mismatch_count, 32'd0);
    chk("c4_first", first_mismatch_idx, 32'hFFFFFFFF);
    chk("c4_pass", 32'(pass), 32'd1);

    // Case 5: runtime base 0x3000, word 2 differs.
    setup_sig(32'h3000, 32'h3000, 4);
    mem_img[2] = 32'hDEADBEEF;
    ref_img[2] = 32'h0;
    do_reset();
    run_hits(8);
    wait_done(40, "c5_done");
    chk("c5_addr0", addr_log[0], 32'h3000);
    chk("c5_addr3", addr_log[3], 32'h300C);
    chk("c5_words", words_checked, 32'd4);
    chk("c5_mism", mismatch_count, 32'd1);
    chk("c5_first", first_mismatch_idx, 32'd2);
    chk("c5_pass", 32'(pass), 32'd0);

    // Case 6: reference list longer than SIG_WORDS stops at the limit.
    setup_sig(32'h0, 32'h2000, 8);
    ref_img[5] = 32'h1;
    ref_img[4] = 32'h2;
    do_reset();
    run_hits(8);
    wait_done(40, "c6_done");
    chk("c6_words", words_checked, 32'd6);
    chk("c6_nreads", n_log, 32'd6);
    chk("c6_mism", mismatch_count, 32'd2);
    chk("c6_first", first_mismatch_idx, 32'd4);
    chk("c6_pass", 32'(pass), 32'd0);

    // Case 7: empty reference list fails.
    setup_sig(32'h0, 32'h2000, 0);
    do_reset();
    run_hits(8);
    wait_done(40, "c7_done");
    chk("c7_words", words_checked, 32'd0);
    chk("c7_pass", 32'(pass), 32'd0);

    // Case 8: reset pulsed while in SCAN_CMP with a pending mismatch.
    setup_sig(32'h0, 32'h2000, 4);
    mem_img[0] = 32'h0BADF00D;
    do_reset();
    run_hits(8);
    chk("c8_rd_en_req", 32'(mem_rd_en), 32'd1);
    step();
    chk("c8_rd_en_cmp", 32'(mem_rd_en), 32'd0);
    cpurst = 1'b1;
    step();
    cpurst = 1'b0;
    chk("c8_done", 32'(done), 32'd0);
    chk("c8_cycle", cycle_count, 32'd0);
    chk("c8_instret", instret_count, 32'd0);
    chk("c8_words", words_checked, 32'd0);
    chk("c8_mism", mismatch_count, 32'd0);
    chk("c8_first", first_mismatch_idx, 32'hFFFFFFFF);
    chk("c8_rd_en", 32'(mem_rd_en), 32'd0);
    inst_valid = 1'b1;
    inst_pc = O;
    step();
    inst_valid = 1'b0;
    chk("c8_run_cycle", cycle_count, 32'd1);
    chk("c8_run_instret", instret_count, 32'd1);
`else
    // Case 4: gp != 1 at end fails; later gp changes are not resampled.
    gp_value = 32'd5;
    do_reset();
    run_hits(8);
    chk("c4_done", 32'(done), 32'd1);
    chk("c4_pass", 32'(pass), 32'd0);
    gp_value = 32'd1;
    step();
    chk("c4_pass_held", 32'(pass), 32'd0);
    chk("c4_words", words_checked, 32'd0);
    chk("c4_first", first_mismatch_idx, 32'hFFFFFFFF);
    chk("c4_rd_addr", mem_rd_addr, 32'd0);
    chk("c4_ref_idx", ref_rd_idx, 32'd0);

    // Case 5: reset while in DONE restarts the run.
    cpurst = 1'b1;
    step();
    cpurst = 1'b0;
    chk("c5_done", 32'(done), 32'd0);
    chk("c5_pass", 32'(pass), 32'd0);
    chk("c5_cycle", cycle_count, 32'd0);
    chk("c5_instret", instret_count, 32'd0);
    inst_valid = 1'b1;
    inst_pc = H;
    step();
    inst_valid = 1'b0;
    chk("c5_run_cycle", cycle_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sim_end_monitor.md
Name: sim_end_monitor

Overview:
- Parametrised end-of-test monitor, instantiated beside `top` in the core testbench.
- Counts cycles and retired instructions, and detects test end by counting the tohost PC being retired.
- Enforces a cycle-timeout watchdog.
- On end, walks the signature region through a data-memory read port and compares it word-by-word against an expected-signature port, then raises `done`/`pass`.

Parameters:
- XLEN, 32, width of PC, address and data buses.
- CNT_W, 32, width of all counters.
- TOHOST_PC, 32'h00000086, PC whose retirement marks a write_tohost pass.
- TOHOST_HITS, 8, number of tohost retirements that end the run (≥1).
- TIMEOUT_CYCLES, 50000, cycles in RUN before forced fail (≥2).
- SIG_BASE_DEFAULT, 32'h00002000, signature base used when `sig_base` = 0.
- SIG_WORDS, 1024, maximum number of signature words compared.

Ports:
- clk  in  1  clock.
- cpurst  in  1  synchronous active-high reset.
- inst_valid  in  1  an instruction is issued to EX this cycle (de2ex valid).
- inst_pc  in  XLEN  PC of that instruction (fe2de PC).
- gp_value  in  XLEN  architectural x3, used for pass when signature check is compiled out.
- sig_base  in  XLEN  runtime signature base, word aligned; 0 selects SIG_BASE_DEFAULT.
- mem_rd_en  out  1  data-memory read strobe.
- mem_rd_addr  out  XLEN  byte address, word aligned.
- mem_rd_data  in  XLEN  read data, valid the cycle after `mem_rd_en`.
- ref_rd_idx  out  CNT_W  expected-signature word index.
- ref_rd_data  in  XLEN  expected word, valid the cycle after the index is driven.
- ref_rd_valid  in  1  expected word exists; 0 marks end of list.
- done  out  1  run finished, sticky.
- pass  out  1  result, meaningful only when `done` = 1.
- timeout  out  1  run ended by watchdog.
- cycle_count  out  CNT_W  cycles spent in RUN.
- instret_count  out  CNT_W  `inst_valid` cycles in RUN.
- words_checked  out  CNT_W  signature words compared.
- mismatch_count  out  CNT_W  words that differed.
- first_mismatch_idx  out  CNT_W  index of first differing word; all-ones if none.

Behaviour:
- Reset (`cpurst`=1 at posedge): state←RUN. All counters 0; `done`/`pass`/`timeout`/`mem_rd_en` 0; `first_mismatch_idx` all-ones; hit counter 0.
  - Reset asserted in any state, including mid-scan, aborts and restarts identically.
- States:
  - RUN, SCAN_REQ, SCAN_CMP, DONE.
- RUN:
  - `cycle_count` increments every cycle.
  - `instret_count` increments when `inst_valid`=1.
  - The hit counter increments when `inst_valid` && `inst_pc`==TOHOST_PC.
  - End condition: the increment makes hits == TOHOST_HITS. Counters freeze (the ending cycle is counted) and the state goes to SCAN_REQ (DONE if the feature is compiled out).
  - Timeout condition: `cycle_count` == TIMEOUT_CYCLES-1 without the end condition. State goes to DONE with `timeout`=1 and `pass`=0.
  - If both conditions occur in the same cycle, the end condition wins.
- SCAN_REQ (one cycle):
  - `mem_rd_en`=1.
  - `mem_rd_addr` = base + 4*`words_checked`, where base = `sig_base` ? `sig_base` : SIG_BASE_DEFAULT, sampled on RUN exit.
  - `ref_rd_idx` = `words_checked`.
  - Next state is SCAN_CMP.
- SCAN_CMP (one cycle, `mem_rd_en`=0):
  - If `ref_rd_valid`=0, go to DONE.
  - Otherwise:
    - If `mem_rd_data` != `ref_rd_data`: `mismatch_count`++, and `first_mismatch_idx` is latched if still all-ones.
    - `words_checked`++.
    - If the new `words_checked` == SIG_WORDS, go to DONE; else go to SCAN_REQ.
  - Throughput is 2 cycles per word; address arithmetic wraps modulo 2^XLEN.
- DONE:
  - `done`=1 (asserted on DONE entry and held until reset).
  - `pass` = !`timeout` && `mismatch_count`==0 && `words_checked`≥1.
  - An empty reference list fails.
  - All outputs hold; further `inst_valid` activity is ignored.
- Outputs are registered; no combinational input-to-output paths except `mem_rd_addr`/`ref_rd_idx`, which come from registered state.

Optional Feature:
- SIM_END_SIG_CHECK_EN defined:
  - Signature scan as above.
- Undefined:
  - SCAN states, `mem_rd_*` and `ref_rd_idx` logic are removed; outputs are tied to 0.
  - RUN end goes directly to DONE.
  - `pass` = !`timeout` && `gp_value`==1, with `gp_value` sampled on the RUN→DONE transition.
  - `words_checked`=0, `mismatch_count`=0, `first_mismatch_idx` all-ones.

Test Plan:
- Retire PC 0x86 eight times with 3 other instructions by cycle 40 (feature off, `gp_value`=1) → `done`=1 in DONE at the cycle after the 8th hit, `pass`=1, `instret_count`=11, `cycle_count` frozen.
- No tohost hits, TIMEOUT_CYCLES=100 → `done`=1 and `timeout`=1 after 100 RUN cycles, `pass`=0, `cycle_count`=99.
- Feature on, `sig_base`=0, 4 ref words matching mem, 5th `ref_rd_valid`=0 → reads at 0x2000..0x200C, `words_checked`=4, `mismatch_count`=0, `pass`=1.
- Feature on, `sig_base`=0x3000, word 2 differs (0xDEADBEEF vs 0x0) → `mismatch_count`=1, `first_mismatch_idx`=2, `pass`=0.
- 8th tohost hit in the same cycle as the timeout cycle → scan entered, `timeout`=0.
- `cpurst` pulsed during SCAN_CMP → next cycle in RUN, all counters 0, `done`=0, `first_mismatch_idx`=0xFFFFFFFF.
